mac_accumulate: RTL

Per-lane int8 multiply-accumulate stage that sits directly upstream of the requantize stage. It consumes SIZE parallel signed 8-bit activation/weight pairs per accepted beat. Over DEPTH beats it sums the products onto a per-lane 32-bit bias and emits one SIZE-wide vector of signed 32-bit accumulators. That vector is packed exactly as the requantize stage's 32-bit-per-lane input expects. Valid/ready handshakes on both sides let the stage stall against downstream backpressure.

---
 rtl/parcnn_pkg.sv | 33 +++
 rtl/mac_lane.sv | 34 +++
 rtl/mac_accumulate.sv | 86 ++++++++
 3 files changed

// File: rtl/parcnn_pkg.sv
// Shared widths, saturation limits and helpers
// for the int8 conv datapath stages.
package parcnn_pkg;

    localparam int ACC_W  = 32;
    localparam int Q_W    = 8;
    localparam int PROD_W = 16;

    localparam logic [ACC_W-1:0] ACC_MAX = 32'h7FFF_FFFF;
    localparam logic [ACC_W-1:0] ACC_MIN = 32'h8000_0000;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } buf_state_t;

    function automatic int lane_lo(input int lane, input int w);
        return lane * w;
    endfunction

    // Top two bits disagree only when the 33-bit sum left int32 range.
    function automatic logic [ACC_W-1:0] sat32(
        input logic [ACC_W:0] s
    );
        logic [ACC_W-1:0] r;
        if (s[ACC_W] != s[ACC_W-1])
            r = s[ACC_W] ? ACC_MIN : ACC_MAX;
        else
            r = s[ACC_W-1:0];
        return r;
    endfunction

endpackage

// File: rtl/mac_lane.sv
// One multiply-accumulate lane: int8 x int8 product added
// onto bias or running sum, saturated to int32.
module mac_lane
    import parcnn_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    first,
    input  logic signed [Q_W-1:0]   pixel,
    input  logic signed [Q_W-1:0]   weight,
    input  logic [ACC_W-1:0]        bias,
    output logic [ACC_W-1:0]        sum
);

    logic signed [PROD_W-1:0] prod;
    logic [ACC_W-1:0]         acc;
    logic [ACC_W-1:0]         base;
    logic [ACC_W:0]           wide;

    assign prod = pixel * weight;
    assign base = first ? bias : acc;
    assign wide = {base[ACC_W-1], base}
                + {{(ACC_W+1-PROD_W){prod[PROD_W-1]}}, prod};
    assign sum  = sat32(wide);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            acc <= '0;
        else if (en)
            acc <= sum;
    end

endmodule

// File: rtl/mac_accumulate.sv
// SIZE-lane int8 MAC over DEPTH beats with a one-entry
// output register and valid/ready handshakes.
module mac_accumulate
    import parcnn_pkg::*;
#(
    parameter int SIZE  = 4,
    parameter int DEPTH = 9
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [Q_W*SIZE-1:0]     pixel_in,
    input  logic [Q_W*SIZE-1:0]     weight_in,
    input  logic [ACC_W*SIZE-1:0]   bias_in,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [ACC_W*SIZE-1:0]   pixel_out,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [CNT_W-1:0]        cnt;
    logic                    accept;
    logic                    first;
    logic                    last;
    logic                    done;
    logic [ACC_W*SIZE-1:0]   lane_sum;
    buf_state_t              state;
    buf_state_t              state_nx;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign first    = (cnt == '0);
    assign last     = (cnt == CNT_W'(DEPTH - 1));
    assign done     = accept && last;

    for (genvar i = 0; i < SIZE; i++) begin : g_lane
        mac_lane u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .en     (accept),
            .first  (first),
            .pixel  (pixel_in[lane_lo(i, Q_W) +: Q_W]),
            .weight (weight_in[lane_lo(i, Q_W) +: Q_W]),
            .bias   (bias_in[lane_lo(i, ACC_W) +: ACC_W]),
            .sum    (lane_sum[lane_lo(i, ACC_W) +: ACC_W])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (accept)
            cnt <= last ? '0 : cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= EMPTY;
        else
            state <= state_nx;
    end

    // A completing accept while FULL implies out_ready, so refill wins.
    always_comb begin
        state_nx = state;
        unique case (state)
            EMPTY: if (done) state_nx = FULL;
            FULL:  if (out_ready && !done) state_nx = EMPTY;
            default: state_nx = EMPTY;
        endcase
    end

    always_comb begin
        out_valid = (state == FULL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pixel_out <= '0;
        else if (done)
            pixel_out <= lane_sum;
    end

endmodule
